// File: rtl/rggen_bus_arbiter.sv
// rtl/rggen_bus_arbiter.sv - round-robin arbiter sharing one rggen bus among N requesters
// Optional feature macro: RGGEN_BUS_ARBITER_TIMEOUT_EN (watchdog that completes a stuck transaction with SLVERR)
module rggen_bus_arbiter #(
    parameter int N_REQUESTERS   = 2,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic [N_REQUESTERS-1:0]                i_req_valid,
    input  logic [N_REQUESTERS*2-1:0]              i_req_access,
    input  logic [N_REQUESTERS*ADDRESS_WIDTH-1:0]  i_req_address,
    input  logic [N_REQUESTERS*BUS_WIDTH-1:0]      i_req_write_data,
    input  logic [N_REQUESTERS*(BUS_WIDTH/8)-1:0]  i_req_strobe,
    output logic [N_REQUESTERS-1:0]                o_req_ready,
    output logic [1:0]                             o_req_status,
    output logic [BUS_WIDTH-1:0]                   o_req_read_data,
    output logic                                   o_bus_valid,
    output logic [1:0]                             o_bus_access,
    output logic [ADDRESS_WIDTH-1:0]               o_bus_address,
    output logic [BUS_WIDTH-1:0]                   o_bus_write_data,
    output logic [BUS_WIDTH/8-1:0]                 o_bus_strobe,
    input  logic                                   i_bus_ready,
    input  logic [1:0]                             i_bus_status,
    input  logic [BUS_WIDTH-1:0]                   i_bus_read_data
);

    localparam int PW = (N_REQUESTERS > 1) ? $clog2(N_REQUESTERS) : 1;
    localparam int SW = BUS_WIDTH / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [PW-1:0]            r_ptr;
    logic [PW-1:0]            r_grant;
    logic [1:0]               r_access;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [BUS_WIDTH-1:0]     r_write_data;
    logic [SW-1:0]            r_strobe;

    logic                     w_any;
    logic [PW-1:0]            w_sel;
    logic                     w_timeout;
    logic                     w_done;

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0]            r_to_cnt;

    // Watchdog: held at zero in IDLE so it starts clean on entry to BUSY, counts stalled BUSY cycles
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_to_cnt <= '0;
        end else if (!i_bus_ready) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == BUSY) && !i_bus_ready &&
                       (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // A transaction finishes on downstream ready, or on watchdog expiry when enabled
    assign w_done = (r_state == BUSY) && (i_bus_ready || w_timeout);

    // Round-robin pick: scan from the pointer upward with wrap; the closest set index wins
    always_comb begin
        int v_idx;
        v_idx = 0;
        w_any = |i_req_valid;
        w_sel = '0;
        for (int i = N_REQUESTERS - 1; i >= 0; i--) begin
            v_idx = int'(r_ptr) + i;
            if (v_idx >= N_REQUESTERS) begin
                v_idx = v_idx - N_REQUESTERS;
            end
            if (i_req_valid[v_idx]) begin
                w_sel = PW'(v_idx);
            end
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: grant from IDLE, return to IDLE on completion
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any)  w_next_state = BUSY;
            BUSY:    if (w_done) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Grant capture: the winner's request fields are frozen so the downstream side sees a stable request
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant      <= '0;
            r_access     <= '0;
            r_address    <= '0;
            r_write_data <= '0;
            r_strobe     <= '0;
        end else if ((r_state == IDLE) && w_any) begin
            r_grant      <= w_sel;
            r_access     <= i_req_access[int'(w_sel)*2 +: 2];
            r_address    <= i_req_address[int'(w_sel)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            r_write_data <= i_req_write_data[int'(w_sel)*BUS_WIDTH +: BUS_WIDTH];
            r_strobe     <= i_req_strobe[int'(w_sel)*SW +: SW];
        end
    end

    // Priority pointer moves just past the requester that was served
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (w_done) begin
            r_ptr <= (r_grant == PW'(N_REQUESTERS - 1)) ? '0 : r_grant + 1'b1;
        end
    end

    // Output logic: downstream request in BUSY, one-hot completion with pass-through response
    always_comb begin
        o_bus_valid     = (r_state == BUSY);
        o_req_ready     = '0;
        o_req_status    = 2'b00;
        o_req_read_data = '0;
        for (int i = 0; i < N_REQUESTERS; i++) begin
            o_req_ready[i] = w_done && (r_grant == PW'(i));
        end
        if ((r_state == BUSY) && i_bus_ready) begin
            o_req_status    = i_bus_status;
            o_req_read_data = i_bus_read_data;
        end else if (w_timeout) begin
            o_req_status    = 2'b10;
        end
    end

    assign o_bus_access     = r_access;
    assign o_bus_address    = r_address;
    assign o_bus_write_data = r_write_data;
    assign o_bus_strobe     = r_strobe;

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// tb/tb_rggen_bus_arbiter.sv - table-driven self-checking bench for rggen_bus_arbiter
module tb_rggen_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int BW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*2-1:0]    req_access;
    logic [N*AW-1:0]   req_address;
    logic [N*BW-1:0]   req_wdata;
    logic [N*BW/8-1:0] req_strobe;
    logic [N-1:0]      o_req_ready;
    logic [1:0]        o_req_status;
    logic [BW-1:0]     o_req_read_data;
    logic              o_bus_valid;
    logic [1:0]        o_bus_access;
    logic [AW-1:0]     o_bus_address;
    logic [BW-1:0]     o_bus_write_data;
    logic [BW/8-1:0]   o_bus_strobe;
    logic              bus_ready;
    logic [1:0]        bus_status;
    logic [BW-1:0]     bus_rdata;

    int checks   = 0;
    int failures = 0;

    logic [1:0]  c_acc [N];
    logic [7:0]  c_addr[N];
    logic [31:0] c_data[N];
    logic [3:0]  c_strb[N];

    always #5 clk = ~clk;

    rggen_bus_arbiter #(
        .N_REQUESTERS  (N),
        .ADDRESS_WIDTH (AW),
        .BUS_WIDTH     (BW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_req_valid     (req_valid),
        .i_req_access    (req_access),
        .i_req_address   (req_address),
        .i_req_write_data(req_wdata),
        .i_req_strobe    (req_strobe),
        .o_req_ready     (o_req_ready),
        .o_req_status    (o_req_status),
        .o_req_read_data (o_req_read_data),
        .o_bus_valid     (o_bus_valid),
        .o_bus_access    (o_bus_access),
        .o_bus_address   (o_bus_address),
        .o_bus_write_data(o_bus_write_data),
        .o_bus_strobe    (o_bus_strobe),
        .i_bus_ready     (bus_ready),
        .i_bus_status    (bus_status),
        .i_bus_read_data (bus_rdata)
    );

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic        rdy;
        logic [1:0]  st;
        logic [31:0] rd;
        logic        e_bv;
        int          e_gnt;
        logic [3:0]  e_rr;
        logic [1:0]  e_st;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(logic r, logic [3:0] v, logic rdy, logic [1:0] st, logic [31:0] rd,
                                logic ebv, int egnt, logic [3:0] err, logic [1:0] est, logic [31:0] erd);
        vec_t t;
        t.rst_n = r;   t.valid = v;  t.rdy = rdy;  t.st = st;  t.rd = rd;
        t.e_bv  = ebv; t.e_gnt = egnt; t.e_rr = err; t.e_st = est; t.e_rd = erd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        c_acc[0] = 2'b01; c_addr[0] = 8'h10; c_data[0] = 32'hDEADBEEF; c_strb[0] = 4'hF;
        c_acc[1] = 2'b10; c_addr[1] = 8'h11; c_data[1] = 32'h10000001; c_strb[1] = 4'h3;
        c_acc[2] = 2'b11; c_addr[2] = 8'h12; c_data[2] = 32'h10000002; c_strb[2] = 4'hC;
        c_acc[3] = 2'b01; c_addr[3] = 8'h13; c_data[3] = 32'h10000003; c_strb[3] = 4'h5;
        for (int i = 0; i < N; i++) begin
            req_access[i*2 +: 2]   = c_acc[i];
            req_address[i*AW +: AW] = c_addr[i];
            req_wdata[i*BW +: BW]   = c_data[i];
            req_strobe[i*4 +: 4]    = c_strb[i];
        end

        //            rst  valid  rdy st    rdata         bv gnt rr     st    rdata
        tbl[0]  = mk(1, 4'b0001, 0, 2'b00, 32'h0,        0, 0, 4'b0000, 2'b00, 32'h0);
        tbl[1]  = mk(1, 4'b0001, 1, 2'b00, 32'h0,        1, 0, 4'b0001, 2'b00, 32'h0);
        tbl[2]  = mk(1, 4'b0000, 0, 2'b00, 32'h0,        0, 0, 4'b0000, 2'b00, 32'h0);
        tbl[3]  = mk(1, 4'b0000, 1, 2'b11, 32'h55555555, 0, 0, 4'b0000, 2'b00, 32'h0);
        tbl[4]  = mk(0, 4'b0011, 0, 2'b00, 32'h0,        0, 0, 4'b0000, 2'b00, 32'h0);
        tbl[5]  = mk(1, 4'b0011, 0, 2'b00, 32'h0,        0, 0, 4'b0000, 2'b00, 32'h0);
        tbl[6]  = mk(1, 4'b0011, 0, 2'b00, 32'h0,        1, 0, 4'b0000, 2'b00, 32'h0);
        tbl[7]  = mk(1, 4'b0011, 1, 2'b00, 32'h0,        1, 0, 4'b0001, 2'b00, 32'h0);
        tbl[8]  = mk(1, 4'b0011, 0, 2'b00, 32'h0,        0, 0, 4'b0000, 2'b00, 32'h0);
        tbl[9]  = mk(1, 4'b0011, 1, 2'b01, 32'h0,        1, 1, 4'b0010, 2'b01, 32'h0);
        tbl[10] = mk(1, 4'b0011, 0, 2'b00, 32'h0,        0, 0, 4'b0000, 2'b00, 32'h0);
        tbl[11] = mk(1, 4'b0011, 1, 2'b00, 32'h0,        1, 0, 4'b0001, 2'b00, 32'h0);
        tbl[12] = mk(1, 4'b0011, 0, 2'b00, 32'h12345678, 0, 0, 4'b0000, 2'b00, 32'h0);
        tbl[13] = mk(1, 4'b0011, 1, 2'b11, 32'h12345678, 1, 1, 4'b0010, 2'b11, 32'h12345678);
        tbl[14] = mk(1, 4'b0100, 0, 2'b00, 32'h0,        0, 0, 4'b0000, 2'b00, 32'h0);
        tbl[15] = mk(1, 4'b1010, 1, 2'b00, 32'h0,        1, 2, 4'b0100, 2'b00, 32'h0);
        tbl[16] = mk(1, 4'b1010, 0, 2'b00, 32'h0,        0, 0, 4'b0000, 2'b00, 32'h0);
        tbl[17] = mk(1, 4'b1010, 1, 2'b10, 32'h0,        1, 3, 4'b1000, 2'b10, 32'h0);
        tbl[18] = mk(1, 4'b0010, 0, 2'b00, 32'h0,        0, 0, 4'b0000, 2'b00, 32'h0);
        tbl[19] = mk(1, 4'b0010, 1, 2'b00, 32'h0,        1, 1, 4'b0010, 2'b00, 32'h0);
        tbl[20] = mk(1, 4'b0000, 0, 2'b00, 32'h0,        0, 0, 4'b0000, 2'b00, 32'h0);

        rst_n      = 1'b0;
        req_valid  = '0;
        bus_ready  = 1'b0;
        bus_status = 2'b00;
        bus_rdata  = '0;
        step();
        step();
        chk("reset bus_valid",   32'(o_bus_valid),      32'h0);
        chk("reset req_ready",   32'(o_req_ready),      32'h0);
        chk("reset status",      32'(o_req_status),     32'h0);
        chk("reset read_data",   o_req_read_data,       32'h0);
        chk("reset bus_address", 32'(o_bus_address),    32'h0);
        chk("reset bus_wdata",   o_bus_write_data,      32'h0);
        chk("reset bus_strobe",  32'(o_bus_strobe),     32'h0);
        chk("reset bus_access",  32'(o_bus_access),     32'h0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 21; v++) begin
            rst_n      = tbl[v].rst_n;
            req_valid  = tbl[v].valid;
            bus_ready  = tbl[v].rdy;
            bus_status = tbl[v].st;
            bus_rdata  = tbl[v].rd;
            #3;
            chk($sformatf("v%0d bus_valid", v), 32'(o_bus_valid), 32'(tbl[v].e_bv));
            if (tbl[v].e_bv) begin
                chk($sformatf("v%0d bus_address", v), 32'(o_bus_address), 32'(c_addr[tbl[v].e_gnt]));
                chk($sformatf("v%0d bus_wdata", v),   o_bus_write_data,    c_data[tbl[v].e_gnt]);
                chk($sformatf("v%0d bus_strobe", v),  32'(o_bus_strobe),   32'(c_strb[tbl[v].e_gnt]));
                chk($sformatf("v%0d bus_access", v),  32'(o_bus_access),   32'(c_acc[tbl[v].e_gnt]));
            end
            chk($sformatf("v%0d req_ready", v), 32'(o_req_ready),  32'(tbl[v].e_rr));
            chk($sformatf("v%0d status", v),    32'(o_req_status), 32'(tbl[v].e_st));
            chk($sformatf("v%0d read_data", v), o_req_read_data,   tbl[v].e_rd);
            step();
        end

        // Stalled downstream: watchdog completion when enabled, indefinite wait otherwise
        bus_ready  = 1'b0;
        bus_status = 2'b00;
        bus_rdata  = 32'hCAFEF00D;
        req_valid  = 4'b0001;
        step();
`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
        for (int k = 1; k <= 3; k++) begin
            #3;
            chk($sformatf("to busy%0d bus_valid", k), 32'(o_bus_valid), 32'h1);
            chk($sformatf("to busy%0d req_ready", k), 32'(o_req_ready), 32'h0);
            step();
        end
        #3;
        chk("to expire req_ready", 32'(o_req_ready),  32'h1);
        chk("to expire status",    32'(o_req_status), 32'h2);
        chk("to expire read_data", o_req_read_data,   32'h0);
        step();
        #3;
        chk("to after bus_valid", 32'(o_bus_valid), 32'h0);
        step();
        for (int k = 1; k <= 3; k++) begin
            #3;
            chk($sformatf("to2 busy%0d req_ready", k), 32'(o_req_ready), 32'h0);
            step();
        end
        bus_ready  = 1'b1;
        bus_status = 2'b01;
        #3;
        chk("to tie req_ready", 32'(o_req_ready),  32'h1);
        chk("to tie status",    32'(o_req_status), 32'h1);
        chk("to tie read_data", o_req_read_data,   32'hCAFEF00D);
        step();
`else
        for (int k = 1; k <= 10; k++) begin
            #3;
            chk($sformatf("stall%0d bus_valid", k), 32'(o_bus_valid), 32'h1);
            chk($sformatf("stall%0d req_ready", k), 32'(o_req_ready), 32'h0);
            step();
        end
        bus_ready = 1'b1;
        #3;
        chk("stall end req_ready", 32'(o_req_ready), 32'h1);
        chk("stall end read_data", o_req_read_data,  32'hCAFEF00D);
        step();
`endif
        bus_ready = 1'b0;
        req_valid = 4'b0000;
        step();

        // Reset in the middle of a transaction, then a stray ready
        req_valid = 4'b0010;
        step();
        #3;
        chk("midrst busy bus_valid", 32'(o_bus_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst bus_valid", 32'(o_bus_valid), 32'h0);
        chk("midrst req_ready", 32'(o_req_ready), 32'h0);
        req_valid = 4'b0000;
        step();
        rst_n     = 1'b1;
        bus_ready = 1'b1;
        #3;
        chk("stray req_ready", 32'(o_req_ready),  32'h0);
        chk("stray bus_valid", 32'(o_bus_valid),  32'h0);
        chk("stray read_data", o_req_read_data,   32'h0);
        step();
        bus_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
